cpu_sequencer: RTL and testbench

Multi-cycle control FSM for the ARM-style CPU datapath (memory, address register/incrementer, data register, instruction register, register bank, barrel shifter, ALU). Replaces the datapath's hard-tied enables with per-state strobes. Sequences fetch, decode, execute, load/store and branch/refill, with a memory-ready handshake, wait-state timeout and a retired-instruction counter.

---
 rtl/cpu_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the ARM-style datapath: fetch, decode, execute,
// load/store, branch/refill, with memory wait-state timeout and retired-instruction count.
module cpu_sequencer #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       cls,
    input  logic             cond_pass,
    input  logic             writes_rd,
    input  logic             writes_pc,
    input  logic             setflags,
    input  logic             mem_ready,
    output logic [3:0]       state,
    output logic [1:0]       addr_sel,
    output logic             mem_req,
    output logic             mem_write,
    output logic             ir_load,
    output logic             incr_en,
    output logic             datareg_in,
    output logic             reg_write,
    output logic             link_write,
    output logic             pc_write,
    output logic             flags_write,
    output logic             fault,
    output logic             retire,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned WAIT_W = 8;

    localparam logic [2:0] CLS_DP  = 3'd0;
    localparam logic [2:0] CLS_LDR = 3'd1;
    localparam logic [2:0] CLS_STR = 3'd2;
    localparam logic [2:0] CLS_B   = 3'd3;
    localparam logic [2:0] CLS_BL  = 3'd4;

    localparam logic [1:0] ASEL_INC = 2'd0;
    localparam logic [1:0] ASEL_ALU = 2'd1;
    localparam logic [1:0] ASEL_PC  = 2'd2;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC    = 4'd3,
        S_MEMADDR = 4'd4,
        S_MEMACC  = 4'd5,
        S_BRANCH  = 4'd6,
        S_REFILL  = 4'd7,
        S_FAULT   = 4'd8
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          cls_q;
    logic                wrd_q, wpc_q, sf_q;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                retire_q, retire_d;
    logic                fault_q, fault_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                wait_expired;

    // State, latched decode fields, wait counter and retirement bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            cls_q     <= 3'd0;
            wrd_q     <= 1'b0;
            wpc_q     <= 1'b0;
            sf_q      <= 1'b0;
            wait_q    <= '0;
            retire_q  <= 1'b0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            retire_q  <= retire_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
            if (state_q == S_DECODE) begin
                cls_q <= cls;
                wrd_q <= writes_rd;
                wpc_q <= writes_pc;
                sf_q  <= setflags;
            end
        end
    end

    assign wait_expired = (wait_q == WAIT_W'(WAIT_MAX)) && !mem_ready;

    // Next state plus per-state strobes; ready-qualified strobes follow mem_ready directly
    always_comb begin
        state_d     = state_q;
        addr_sel    = ASEL_INC;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        ir_load     = 1'b0;
        incr_en     = 1'b0;
        datareg_in  = 1'b0;
        reg_write   = 1'b0;
        link_write  = 1'b0;
        pc_write    = 1'b0;
        flags_write = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    incr_en = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                if (!cond_pass) begin
                    state_d = S_FETCH;
                end else begin
                    case (cls)
                        CLS_DP:          state_d = S_EXEC;
                        CLS_LDR, CLS_STR: state_d = S_MEMADDR;
                        CLS_B, CLS_BL:   state_d = S_BRANCH;
                        default:         state_d = S_FAULT;
                    endcase
                end
            end
            S_EXEC: begin
                reg_write   = wrd_q;
                flags_write = sf_q;
                state_d     = (wpc_q && wrd_q) ? S_REFILL : S_FETCH;
            end
            S_MEMADDR: begin
                addr_sel   = ASEL_ALU;
                datareg_in = (cls_q == CLS_STR);
                state_d    = S_MEMACC;
            end
            S_MEMACC: begin
                addr_sel  = ASEL_ALU;
                mem_req   = 1'b1;
                mem_write = (cls_q == CLS_STR);
                if (mem_ready) begin
                    reg_write = (cls_q == CLS_LDR);
                    state_d   = ((cls_q == CLS_LDR) && wpc_q) ? S_REFILL : S_FETCH;
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_BRANCH: begin
                pc_write   = 1'b1;
                link_write = (cls_q == CLS_BL);
                state_d    = S_REFILL;
            end
            S_REFILL: begin
                addr_sel = ASEL_PC;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase

        // Counter restarts on every state change, so entry into FETCH/MEMACC sees zero
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (((state_q == S_FETCH) || (state_q == S_MEMACC)) && !mem_ready) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = wait_q;
        end

        retire_d  = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_RESET);
        retired_d = retire_d ? (retired_q + CNT_W'(1)) : retired_q;
        fault_d   = (state_d == S_FAULT);
    end

    assign state   = state_q;
    assign fault   = fault_q;
    assign retire  = retire_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Instruction-level reference model for cpu_sequencer: each instruction expands into
// its expected per-cycle output trace, compared against the DUT on every falling edge.
module tb_cpu_sequencer;

    localparam int unsigned WM = 3;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    cls;
    logic          cond_pass, writes_rd, writes_pc, setflags, mem_ready;
    logic [3:0]    state;
    logic [1:0]    addr_sel;
    logic          mem_req, mem_write, ir_load, incr_en, datareg_in;
    logic          reg_write, link_write, pc_write, flags_write, fault, retire;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    cpu_sequencer #(.WAIT_MAX(WM), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cls(cls), .cond_pass(cond_pass),
        .writes_rd(writes_rd), .writes_pc(writes_pc), .setflags(setflags),
        .mem_ready(mem_ready), .state(state), .addr_sel(addr_sel),
        .mem_req(mem_req), .mem_write(mem_write), .ir_load(ir_load),
        .incr_en(incr_en), .datareg_in(datareg_in), .reg_write(reg_write),
        .link_write(link_write), .pc_write(pc_write), .flags_write(flags_write),
        .fault(fault), .retire(retire), .retired(retired)
    );

    typedef struct packed {
        logic [3:0]    st;
        logic [1:0]    asel;
        logic          req, wr, irl, inc, dri, rw, lw, pw, fw, flt, ret;
        logic [CW-1:0] cnt;
    } exp_t;

    logic [$bits(exp_t)-1:0] obs;
    assign obs = {state, addr_sel, mem_req, mem_write, ir_load, incr_en, datareg_in,
                  reg_write, link_write, pc_write, flags_write, fault, retire, retired};

    exp_t        e, exp_q;
    bit          chk_en = 1'b0;
    bit          m_pulse;
    int unsigned m_ret;
    int          errors = 0;
    int          checks = 0;
    int          cyc_n  = 0;

    // Per-cycle comparison against the model trace plus structural invariants
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (obs !== exp_q) begin
                errors++;
                $display("FAIL cyc%0d outputs: got %h want %h (state got %0d want %0d)",
                         cyc_n, obs, exp_q, state, exp_q.st);
            end
            checks++;
            if ((mem_write && !mem_req) || (reg_write && link_write)) begin
                errors++;
                $display("FAIL cyc%0d strobe exclusivity: got wr=%b req=%b rw=%b lw=%b want no conflict",
                         cyc_n, mem_write, mem_req, reg_write, link_write);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic junk();
        cls       = 3'($urandom);
        cond_pass = 1'($urandom);
        writes_rd = 1'($urandom);
        writes_pc = 1'($urandom);
        setflags  = 1'($urandom);
        mem_ready = 1'($urandom);
    endtask

    task automatic tick();
        e.flt  = (e.st == 4'd8);
        e.ret  = m_pulse;
        e.cnt  = CW'(m_ret);
        exp_q  = e;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        m_pulse = 1'b0;
        cyc_n++;
        e = '0;
    endtask

    task automatic retire_now();
        m_ret++;
        m_pulse = 1'b1;
    endtask

    // Fault after WM+1 consecutive not-ready cycles; otherwise caller issues the ready cycle
    task automatic mem_wait(input exp_t base, input int nlow, output bit faulted);
        faulted = 1'b0;
        for (int k = 0; k < nlow; k++) begin
            junk();
            mem_ready = 1'b0;
            e = base;
            tick();
            if (k == int'(WM)) begin
                faulted = 1'b1;
                return;
            end
        end
    endtask

    task automatic refill();
        junk();
        e = '0; e.st = 4'd7; e.asel = 2'd2; e.pw = 1'b1;
        tick();
        retire_now();
    endtask

    task automatic do_instr(input logic [2:0] c, input bit cp, input bit wrd, input bit wpc,
                            input bit sf, input int fwait, input int mwait, output bit faulted);
        exp_t base;
        bit   f;
        faulted = 1'b0;
        base = '0; base.st = 4'd1; base.req = 1'b1;
        mem_wait(base, fwait, f);
        if (f) begin faulted = 1'b1; return; end
        junk(); mem_ready = 1'b1;
        e = base; e.irl = 1'b1; e.inc = 1'b1;
        tick();
        cls = c; cond_pass = cp; writes_rd = wrd; writes_pc = wpc; setflags = sf;
        mem_ready = 1'($urandom);
        e = '0; e.st = 4'd2;
        tick();
        if (!cp) begin retire_now(); return; end
        case (c)
            3'd0: begin
                junk();
                e.st = 4'd3; e.rw = wrd; e.fw = sf;
                tick();
                if (wpc && wrd) refill(); else retire_now();
            end
            3'd1, 3'd2: begin
                junk();
                e.st = 4'd4; e.asel = 2'd1; e.dri = (c == 3'd2);
                tick();
                base = '0; base.st = 4'd5; base.req = 1'b1; base.asel = 2'd1; base.wr = (c == 3'd2);
                mem_wait(base, mwait, f);
                if (f) begin faulted = 1'b1; return; end
                junk(); mem_ready = 1'b1;
                e = base; e.rw = (c == 3'd1);
                tick();
                if (c == 3'd1 && wpc) refill(); else retire_now();
            end
            3'd3, 3'd4: begin
                junk();
                e.st = 4'd6; e.pw = 1'b1; e.lw = (c == 3'd4);
                tick();
                refill();
            end
            default: faulted = 1'b1;
        endcase
    endtask

    task automatic fault_hold(input int n);
        for (int k = 0; k < n; k++) begin
            junk();
            e = '0; e.st = 4'd8;
            tick();
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before the next edge
    task automatic do_reset();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #2;
        chk("reset state", 32'(state), 32'd0);
        chk("reset fault", 32'(fault), 32'd0);
        chk("reset retired", 32'(retired), 32'd0);
        chk("reset all outputs", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ret   = 0;
        m_pulse = 1'b0;
        junk();
        e = '0; e.st = 4'd0;
        tick();
    endtask

    initial begin
        bit f;
        int fw, mw;
        logic [2:0] c;
        rst_n = 1'b0;
        cls = 3'd0; cond_pass = 1'b0; writes_rd = 1'b0; writes_pc = 1'b0;
        setflags = 1'b0; mem_ready = 1'b0;
        m_ret = 0; m_pulse = 1'b0; e = '0;
        @(posedge clk);
        #1;
        do_reset();

        do_instr(3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, f);
        chk("dp retired", 32'(retired), 32'd1);
        chk("dp retire pulse", 32'(retire), 32'd1);
        do_instr(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2, f);
        do_instr(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1, f);
        do_instr(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, f);
        chk("bl retired", 32'(retired), 32'd4);
        do_instr(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, int'(WM), int'(WM), f);
        chk("max wait no fault", 32'(fault), 32'd0);
        do_instr(3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, f);
        do_instr(3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, f);
        do_instr(3'd7, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, f);
        chk("undef skipped fault", 32'(fault), 32'd0);
        chk("undef skipped retired", 32'(retired), 32'd8);
        do_instr(3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, f);
        fault_hold(20);
        chk("undef fault sticky", 32'(fault), 32'd1);
        do_reset();

        do_instr(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, int'(WM) + 1, 0, f);
        fault_hold(2);
        chk("timeout fault", 32'(fault), 32'd1);
        do_reset();

        for (int i = 0; i < 17; i++) do_instr(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, f);
        chk("retired wrap", 32'(retired), 32'd1);

        for (int i = 0; i < 300; i++) begin
            c  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            fw = ($urandom_range(0, 15) == 0) ? int'(WM) + 1 : int'($urandom_range(0, WM));
            mw = ($urandom_range(0, 15) == 0) ? int'(WM) + 1 : int'($urandom_range(0, WM));
            do_instr(c, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                     fw, mw, f);
            if (f) begin
                fault_hold(int'($urandom_range(1, 4)));
                do_reset();
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
